// File: rtl/game_round_ctrl.sv
// Memory-game round sequencer: game FSM, user-counter control, sequence display stepping, win/lose.
// Optional GAME_TIMEOUT_EN adds a WAIT-state inactivity timer of TIMEOUT cycles.
module game_round_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic       enter,
  input  logic       match,
  input  logic [3:0] level,
  input  logic       tc_user,
  output logic       R_user,
  output logic       E_user,
  output logic [3:0] data_user,
  output logic       E_seq,
  output logic [3:0] disp_idx,
  output logic [3:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHOW, S_WAIT, S_CHECK, S_NEXT, S_WIN, S_LOSE
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_round, w_round_nxt;
  logic [3:0] r_disp_idx, w_disp_nxt;
  logic [3:0] r_last, w_last_nxt;
  logic       r_win, w_win_nxt;
  logic       r_lose, w_lose_nxt;
  logic       w_timeout;

`ifdef GAME_TIMEOUT_EN
  logic [7:0] r_timer;

  // Timer only runs in WAIT, so every entry into WAIT starts it from zero.
  always_ff @(posedge clk) begin
    if (R) begin
      r_timer <= 8'd0;
    end else if (r_state == S_WAIT) begin
      r_timer <= r_timer + 8'd1;
    end else begin
      r_timer <= 8'd0;
    end
  end

  assign w_timeout = (r_timer == 8'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (R) begin
      r_state    <= S_IDLE;
      r_round    <= 4'd0;
      r_disp_idx <= 4'd0;
      r_last     <= 4'd0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_round    <= w_round_nxt;
      r_disp_idx <= w_disp_nxt;
      r_last     <= w_last_nxt;
      r_win      <= w_win_nxt;
      r_lose     <= w_lose_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_disp_nxt  = r_disp_idx;
    w_last_nxt  = r_last;
    w_win_nxt   = r_win;
    w_lose_nxt  = r_lose;
    case (r_state)
      // Game bookkeeping is cleared on the way into SETUP so SETUP already shows a fresh game.
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          w_state_nxt = S_SETUP;
          w_round_nxt = 4'd0;
          w_disp_nxt  = 4'd0;
          w_win_nxt   = 1'b0;
          w_lose_nxt  = 1'b0;
        end
      end
      S_SETUP: begin
        w_last_nxt  = level;
        w_state_nxt = S_SHOW;
      end
      S_SHOW: begin
        if (r_disp_idx == r_round) begin
          w_state_nxt = S_WAIT;
          w_disp_nxt  = 4'd0;
        end else begin
          w_disp_nxt  = r_disp_idx + 4'd1;
        end
      end
      S_WAIT: begin
        if (enter) begin
          if (match) begin
            w_state_nxt = S_CHECK;
          end else begin
            w_state_nxt = S_LOSE;
            w_lose_nxt  = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = S_LOSE;
          w_lose_nxt  = 1'b1;
        end
      end
      S_CHECK: begin
        w_state_nxt = tc_user ? S_NEXT : S_WAIT;
      end
      S_NEXT: begin
        if (r_round == r_last) begin
          w_state_nxt = S_WIN;
          w_win_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_SHOW;
          w_round_nxt = r_round + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The final NEXT does not clear the user counter; the round is over, not restarting.
  assign R_user    = (r_state == S_SETUP) || ((r_state == S_NEXT) && (r_round != r_last));
  assign E_user    = (r_state == S_WAIT) && enter && match;
  assign E_seq     = (r_state == S_SHOW);
  assign busy      = !((r_state == S_IDLE) || (r_state == S_WIN) || (r_state == S_LOSE));
  assign data_user = r_round;
  assign disp_idx  = r_disp_idx;
  assign round     = r_round;
  assign win       = r_win;
  assign lose      = r_lose;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomised games against an event-level model of a memory game; a monitor pops expected events.
module tb_game_round_ctrl;
  logic       clk = 1'b0;
  logic       R = 1'b1;
  logic       start = 1'b0;
  logic       enter = 1'b0;
  logic       match = 1'b0;
  logic [3:0] level = 4'd0;
  logic       tc_user = 1'b0;
  logic       R_user, E_user, E_seq, busy, win, lose;
  logic [3:0] data_user, disp_idx, round;

  game_round_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .R(R), .start(start), .enter(enter), .match(match), .level(level),
    .tc_user(tc_user), .R_user(R_user), .E_user(E_user), .data_user(data_user),
    .E_seq(E_seq), .disp_idx(disp_idx), .round(round), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Environment user counter: registered sticky terminal count after data_user+1 increments.
  logic [4:0] ucnt = 5'd0;
  always @(posedge clk) begin
    if (R_user) begin
      ucnt    <= 5'd0;
      tc_user <= 1'b0;
    end else if (E_user) begin
      ucnt <= ucnt + 5'd1;
      if (ucnt == {1'b0, data_user}) tc_user <= 1'b1;
    end
  end

  localparam int EV_SHOW = 0, EV_USER = 1, EV_WIN = 2, EV_LOSE = 3;
  typedef struct { int kind; int a; int b; } ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int ruser_cnt = 0;

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_ev(input int kind, input int a, input int b);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d expected none", kind, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        n_fail++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic win_d, lose_d;
    win_d = 1'b0; lose_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!R) begin
        if (R_user) ruser_cnt++;
        if (E_seq) check_ev(EV_SHOW, int'(disp_idx), int'(round));
        if (E_user) check_ev(EV_USER, int'(round), 0);
        if (win && !win_d) check_ev(EV_WIN, int'(round), 0);
        if (lose && !lose_d) check_ev(EV_LOSE, int'(round), 0);
      end
      win_d = win;
      lose_d = lose;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_show_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !E_seq; i++) tick();
    if (!E_seq) begin
      check("show_start_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < 40 && E_seq; i++) tick();
    if (E_seq) begin
      check("show_end_timeout", 0, 1);
      return;
    end
    ok = 1'b1;
  endtask

  task automatic do_reset;
    R = 1'b1;
    tick();
    tick();
    R = 1'b0;
    exp_q.delete();
  endtask

  // fr < 0: every entry correct. Otherwise entry fe of round fr is wrong.
  task automatic play_game(input int L, input int fr, input int fe);
    bit ok, done;
    int n_ent, exp_ruser;
    // Model: round r replays elements 0..r, then takes r+1 entries.
    done = 1'b0;
    for (int r = 0; r <= L && !done; r++) begin
      for (int d = 0; d <= r; d++) push(EV_SHOW, d, r);
      if (r == fr) begin
        for (int e = 0; e < fe; e++) push(EV_USER, r, 0);
        push(EV_LOSE, r, 0);
        done = 1'b1;
      end else begin
        for (int e = 0; e <= r; e++) push(EV_USER, r, 0);
      end
    end
    if (fr < 0) push(EV_WIN, L, 0);
    exp_ruser = (fr < 0) ? L + 1 : fr + 1;

    ruser_cnt = 0;
    level = 4'(L);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("setup_flags{R_user,win,lose,busy}", int'({R_user, win, lose, busy}), 4'b1001);
    check("setup_round", int'(round), 0);

    done = 1'b0;
    for (int r = 0; r <= L && !done; r++) begin
      wait_show_end(ok);
      if (!ok) begin
        do_reset();
        return;
      end
      n_ent = (r == fr) ? fe + 1 : r + 1;
      for (int e = 0; e < n_ent; e++) begin
        repeat ($urandom_range(0, 3)) tick();
        enter = 1'b1;
        match = !(r == fr && e == fe);
        start = 1'($urandom_range(0, 1));
        tick();
        enter = 1'b0;
        match = 1'b0;
        start = 1'b0;
        if (r == fr && e == fe) begin
          check("lose_next{lose,busy,E_user}", int'({lose, busy, E_user}), 3'b100);
          done = 1'b1;
        end else begin
          tick();
        end
      end
    end
    if (fr < 0) begin
      tick();
      check("win_state{win,lose,busy}", int'({win, lose, busy}), 3'b100);
      check("win_round", int'(round), L);
    end
    tick();
    check("r_user_pulses", ruser_cnt, exp_ruser);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int L, fr, fe;
    tick();
    check("reset_outputs", int'({R_user, E_user, E_seq, busy, win, lose, disp_idx, round, data_user}), 0);
    tick();
    R = 1'b0;
    tick();
    check("idle_busy", int'(busy), 0);

    play_game(0, -1, 0);
    play_game(2, -1, 0);
    play_game(3, 1, 1);
    play_game(1, 0, 0);

    // Abort mid-SHOW.
    level = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("in_show", int'(E_seq), 1);
    R = 1'b1;
    tick();
    check("abort_outputs", int'({R_user, E_user, E_seq, busy, win, lose, disp_idx, round}), 0);
    tick();
    R = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("abort_stays_idle", int'({busy, E_seq, R_user}), 0);

    play_game(4, -1, 0);

    for (int g = 0; g < 12; g++) begin
      L = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) begin
        fr = -1;
        fe = 0;
      end else begin
        fr = $urandom_range(0, L);
        fe = $urandom_range(0, fr);
      end
      play_game(L, fr, fe);
    end

    play_game(15, -1, 0);
    check("l15_no_wrap", int'(round), 15);

`ifdef GAME_TIMEOUT_EN
    push(EV_SHOW, 0, 0);
    push(EV_LOSE, 0, 0);
    level = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_show_end(ok);
    repeat (7) tick();
    check("timeout_wait8_lose", int'(lose), 0);
    tick();
    check("timeout_lose", int'({lose, busy}), 2'b10);
    tick();
    check("timeout_queue", exp_q.size(), 0);

    push(EV_SHOW, 0, 0);
    push(EV_USER, 0, 0);
    push(EV_WIN, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_show_end(ok);
    repeat (7) tick();
    enter = 1'b1;
    match = 1'b1;
    tick();
    enter = 1'b0;
    match = 1'b0;
    check("late_enter_check{lose,busy}", int'({lose, busy}), 2'b01);
    tick();
    tick();
    check("late_enter_win", int'(win), 1);
    tick();
    check("late_enter_queue", exp_q.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Round sequencer for the memory game: owns the game FSM, drives the user-input counter (clear, enable, limit), steps the sequence display and decides win/lose. It sits between the user input/compare logic and the user counter, whose terminal-count output it consumes. The round index grows from 0 to a selectable last level, and each round replays the sequence before accepting user input.

## Interface
- TIMEOUT, 8: idle cycles allowed in WAIT before loss (≥2, ≤255); only used with GAME_TIMEOUT_EN
- clk  in  1  clock, all logic on rising edge
- R  in  1  synchronous reset, active-high
- start  in  1  begin game (sampled in IDLE, WIN, LOSE only)
- enter  in  1  one-cycle pulse: user entered a symbol
- match  in  1  entered symbol equals expected symbol; valid only when enter=1
- level  in  4  index of last round (0..15), sampled in SETUP
- tc_user  in  1  terminal count from user counter (registered, sticky until cleared)
- R_user  out  1  clear to user counter
- E_user  out  1  increment enable to user counter
- data_user  out  4  count limit to user counter (= round)
- E_seq  out  1  sequence display active
- disp_idx  out  4  sequence element currently displayed
- round  out  4  current round index
- busy  out  1  game in progress (state not IDLE/WIN/LOSE)
- win  out  1  game won, held
- lose  out  1  game lost, held

## Operation
- States: IDLE, SETUP, SHOW, WAIT, CHECK, NEXT, WIN, LOSE.
- IDLE: start → SETUP.
- SETUP: R_user=1; latch level into last; round←0; disp_idx←0; win,lose←0 → SHOW.
- SHOW: E_seq=1; disp_idx is the displayed element; if disp_idx==round → WAIT, disp_idx←0, timer←0; else disp_idx←disp_idx+1. Shows round+1 elements.
- WAIT: enter&match → E_user=1 (same cycle), → CHECK. enter&!match → LOSE. No enter: timer increments; timer==TIMEOUT-1 → LOSE.
- CHECK: one cycle for tc_user to settle; tc_user=1 → NEXT; else → WAIT, timer←0.
- NEXT: round==last → WIN; else round←round+1, R_user=1 → SHOW.
- WIN/LOSE: win/lose=1 held; start → SETUP; other inputs ignored.
- data_user = round at all times; counter thus asserts tc_user on the (round+1)-th correct entry.
- Priority: R over everything; in WAIT enter beats timeout in the same cycle; enter outside WAIT ignored; start outside IDLE/WIN/LOSE ignored.
- round never wraps: level=15 ends in WIN after round 15, never increments past it.

## Timing
- Reset (R=1 at edge): state IDLE, round=0, disp_idx=0, timer=0, win=0, lose=0, all strobes 0, busy=0.
- R mid-game aborts immediately to IDLE; user counter is not cleared by this block until next SETUP.
- State, round, disp_idx, win, lose registered; R_user, E_seq, busy decoded from state (Moore); E_user is Mealy (WAIT & enter & match).
- start at edge k: SETUP in cycle k+1, SHOW cycles k+2..k+2+round, WAIT from k+3+round.
- Correct final entry at edge m: CHECK at m+1, NEXT at m+2, SHOW (or WIN) at m+3.
- Wrong entry at edge m: lose=1 from cycle m+1.

## Configuration
- GAME_TIMEOUT_EN defined: timer and TIMEOUT active as above.
- Undefined: no timer; WAIT waits indefinitely; loss only on mismatch; TIMEOUT ignored.

## Test plan
- R=1 for 2 cycles mid-SHOW → all outputs 0, busy=0, state IDLE next cycle.
- level=0, start, one enter&match → E_seq 1 cycle (disp_idx 0), one E_user pulse, win=1, round=0.
- level=2, all entries correct → SHOW lengths 1,2,3 cycles; E_user pulses 1+2+3=6; R_user pulses 3 (SETUP + 2 NEXT); win=1, round=2.
- level=3, round 1, second entry match=0 → lose=1 next cycle, no E_user that cycle, busy=0.
- GAME_TIMEOUT_EN, TIMEOUT=8, no enter in WAIT → lose=1 after 8 WAIT cycles; enter&match on 8th cycle → CHECK, no loss.
- After WIN, start=1 → SETUP: win=0, round=0, R_user=1 one cycle, new game runs.
